// File: rtl/ctrl_cmd_issuer_if.sv
// Bundles the UART byte streams and the two-phase control bus of ctrl_cmd_issuer.
// The slave modport is the issuer's view; the master modport is the host/bench view.
interface ctrl_cmd_issuer_if;
  logic [7:0]  i_rxdata;
  logic        i_rxvalid;
  logic [15:0] o_inst;
  logic        o_set;
  logic [7:0]  o_txdata;
  logic        o_txwrite;
  logic        i_txfull;
  logic        o_busy;
  logic [7:0]  o_errcnt;

  modport slave (
    input  i_rxdata, i_rxvalid, i_txfull,
    output o_inst, o_set, o_txdata, o_txwrite, o_busy, o_errcnt
  );

  modport master (
    output i_rxdata, i_rxvalid, i_txfull,
    input  o_inst, o_set, o_txdata, o_txwrite, o_busy, o_errcnt
  );
endinterface

// File: rtl/ctrl_cmd_issuer.sv
// Parses SYNC,AH,AL,DH,DL,CK frames from a UART and issues ADDR/DATA words on the control bus.
// Define CTRL_CMD_ECHO_EN to echo AH, AL, DH, DL on the transmitter after every ACK.
module ctrl_cmd_issuer #(
  parameter logic [7:0] SYNC        = 8'hA5,
  parameter int         NREG        = 36,
  parameter int         HOLD_CYCLES = 2,
  parameter int         TIMEOUT     = 100000,
  parameter logic [7:0] ACK         = 8'h06,
  parameter logic [7:0] NAK         = 8'h15
) (
  input  logic             i_clk,
  input  logic             i_rst,
  ctrl_cmd_issuer_if.slave bus
);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [15:0]   NREG_W    = 16'(NREG);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

  // Parse states must stay consecutive: a received byte advances by one encoding step.
  typedef enum logic [3:0] {
    S_SYNC, S_AH, S_AL, S_DH, S_DL, S_CK,
    S_ISSUE_A, S_HOLD, S_ISSUE_D, S_RESP
`ifdef CTRL_CMD_ECHO_EN
    , S_ECHO
`endif
  } state_e;

  function automatic logic [7:0] frame_ck(input logic [31:0] f);
    return f[31:24] ^ f[23:16] ^ f[15:8] ^ f[7:0];
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  state_e        state_q, state_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [31:0]   frame_q, frame_d;
  logic [15:0]   inst_q, inst_d;
  logic          set_q, set_d;
  logic [7:0]    txdata_q, txdata_d;
  logic [7:0]    errcnt_q, errcnt_d;
  logic          busy_q, busy_d;
  logic          txwrite_s;
`ifdef CTRL_CMD_ECHO_EN
  logic [1:0]    echo_idx_q, echo_idx_d;
`endif

  // Next-state, frame capture, issue sequencing and response handshake.
  always_comb begin
    state_d   = state_q;
    tmo_d     = '0;
    hold_d    = hold_q;
    frame_d   = frame_q;
    inst_d    = inst_q;
    set_d     = 1'b0;
    txdata_d  = txdata_q;
    errcnt_d  = errcnt_q;
    txwrite_s = 1'b0;
`ifdef CTRL_CMD_ECHO_EN
    echo_idx_d = echo_idx_q;
`endif
    case (state_q)
      S_SYNC: begin
        if (bus.i_rxvalid && (bus.i_rxdata == SYNC)) state_d = S_AH;
        else                                          state_d = S_SYNC;
      end
      S_AH, S_AL, S_DH, S_DL, S_CK: begin
        // A timeout outranks a byte arriving in the same cycle.
        if (tmo_q == TMO_LAST) begin
          state_d  = S_SYNC;
          errcnt_d = sat_inc(errcnt_q);
        end else if (!bus.i_rxvalid) begin
          tmo_d = tmo_q + TW'(1);
        end else if (state_q != S_CK) begin
          frame_d = {frame_q[23:0], bus.i_rxdata};
          state_d = state_e'(state_q + 4'd1);
        end else if ((bus.i_rxdata != frame_ck(frame_q)) || (frame_q[31:16] >= NREG_W)) begin
          state_d  = S_RESP;
          txdata_d = NAK;
          errcnt_d = sat_inc(errcnt_q);
        end else begin
          state_d = S_ISSUE_A;
          inst_d  = frame_q[31:16];
          set_d   = 1'b1;
        end
      end
      S_ISSUE_A: begin
        state_d = S_HOLD;
        inst_d  = frame_q[15:0];
        hold_d  = '0;
      end
      S_HOLD: begin
        if (hold_q == HOLD_LAST) begin
          state_d = S_ISSUE_D;
          set_d   = 1'b1;
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end
      S_ISSUE_D: begin
        state_d  = S_RESP;
        txdata_d = ACK;
      end
      S_RESP: begin
        txwrite_s = !bus.i_txfull;
        if (bus.i_txfull) begin
          state_d = S_RESP;
`ifdef CTRL_CMD_ECHO_EN
        end else if (txdata_q == ACK) begin
          state_d    = S_ECHO;
          txdata_d   = frame_q[31:24];
          echo_idx_d = 2'd0;
`endif
        end else begin
          state_d = S_SYNC;
        end
      end
`ifdef CTRL_CMD_ECHO_EN
      S_ECHO: begin
        txwrite_s = !bus.i_txfull;
        if (bus.i_txfull) begin
          state_d = S_ECHO;
        end else if (echo_idx_q == 2'd3) begin
          state_d = S_SYNC;
        end else begin
          echo_idx_d = echo_idx_q + 2'd1;
          case (echo_idx_q)
            2'd0:    txdata_d = frame_q[23:16];
            2'd1:    txdata_d = frame_q[15:8];
            default: txdata_d = frame_q[7:0];
          endcase
        end
      end
`endif
      default: state_d = S_SYNC;
    endcase
    busy_d = (state_d != S_SYNC);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= S_SYNC;
      tmo_q    <= '0;
      hold_q   <= '0;
      frame_q  <= 32'h0000_0000;
      inst_q   <= 16'h0000;
      set_q    <= 1'b0;
      txdata_q <= 8'h00;
      errcnt_q <= 8'h00;
      busy_q   <= 1'b0;
`ifdef CTRL_CMD_ECHO_EN
      echo_idx_q <= 2'd0;
`endif
    end else begin
      state_q  <= state_d;
      tmo_q    <= tmo_d;
      hold_q   <= hold_d;
      frame_q  <= frame_d;
      inst_q   <= inst_d;
      set_q    <= set_d;
      txdata_q <= txdata_d;
      errcnt_q <= errcnt_d;
      busy_q   <= busy_d;
`ifdef CTRL_CMD_ECHO_EN
      echo_idx_q <= echo_idx_d;
`endif
    end
  end

  // The write strobe follows i_txfull within the cycle so a freed transmitter is used at once.
  assign bus.o_inst    = inst_q;
  assign bus.o_set     = set_q;
  assign bus.o_txdata  = txdata_q;
  assign bus.o_txwrite = txwrite_s;
  assign bus.o_busy    = busy_q;
  assign bus.o_errcnt  = errcnt_q;
endmodule

// File: tb/tb_ctrl_cmd_issuer.sv
// Directed and randomized frames for ctrl_cmd_issuer, checked against a frame-level reference model.
// Honors CTRL_CMD_ECHO_EN when the design is built with it.
`define CHECK(tag, obs, exp) \
  begin \
    total++; \
    assert ((obs) === (exp)) else begin \
      bad++; \
      $error("FAIL %s: observed=%0h expected=%0h", tag, (obs), (exp)); \
    end \
  end

module tb_ctrl_cmd_issuer;
  localparam int H = 2;
  localparam int T = 300;
  localparam logic [7:0] SYNC_B = 8'hA5;
  localparam logic [7:0] ACK_B  = 8'h06;
  localparam logic [7:0] NAK_B  = 8'h15;

  typedef struct {
    int          cyc;
    logic [15:0] val;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   exp_err = 0;
  logic prev_set = 1'b0;
  ev_t  set_log[$];
  ev_t  tx_log[$];
  logic [15:0] inst_log[int];

  ctrl_cmd_issuer_if bus();

  ctrl_cmd_issuer #(.HOLD_CYCLES(H), .TIMEOUT(T)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: logs strobes with their cycle numbers, sampled on the falling edge.
  always @(negedge clk) begin
    ev_t e;
    if (!rst) begin
      if (bus.o_set) begin
        `CHECK("set_back_to_back", prev_set, 1'b0)
        e.cyc = cyc; e.val = bus.o_inst;
        set_log.push_back(e);
      end
      if (bus.o_txwrite) begin
        e.cyc = cyc; e.val = {8'h00, bus.o_txdata};
        tx_log.push_back(e);
      end
      inst_log[cyc] = bus.o_inst;
    end
    prev_set = bus.o_set;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached before the end of the sequence");
    $fatal(1, "watchdog");
  end

  task automatic clear_logs();
    set_log.delete();
    tx_log.delete();
    inst_log.delete();
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap, output int at);
    repeat (gap) begin @(posedge clk); #1; end
    bus.i_rxvalid = 1'b1;
    bus.i_rxdata  = b;
    at = cyc;
    @(posedge clk); #1;
    bus.i_rxvalid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] ah, al, dh, dl, ck, input int maxgap, output int c);
    int t;
    send_byte(SYNC_B, int'($urandom_range(0, maxgap)), t);
    send_byte(ah, int'($urandom_range(0, maxgap)), t);
    send_byte(al, int'($urandom_range(0, maxgap)), t);
    send_byte(dh, int'($urandom_range(0, maxgap)), t);
    send_byte(dl, int'($urandom_range(0, maxgap)), t);
    send_byte(ck, int'($urandom_range(0, maxgap)), c);
  endtask

  // Reference: a frame is accepted iff its XOR checksum matches and the address is below 36.
  task automatic check_frame(input logic [7:0] ah, al, dh, dl, ck, input int c);
    logic        ok;
    int          n_exp, exp_cyc, wait_n;
    logic [15:0] exp_byte, addr, data;
    logic [7:0]  echo_b[4];
    addr = {ah, al};
    data = {dh, dl};
    echo_b[0] = ah; echo_b[1] = al; echo_b[2] = dh; echo_b[3] = dl;
    ok = (ck == (ah ^ al ^ dh ^ dl)) && (addr < 16'd36);
    n_exp = 1;
`ifdef CTRL_CMD_ECHO_EN
    if (ok) n_exp = 5;
`endif
    exp_cyc  = ok ? c + H + 3 : c + 1;
    exp_byte = ok ? {8'h00, ACK_B} : {8'h00, NAK_B};
    wait_n = 0;
    while ((tx_log.size() < n_exp) && (wait_n < 40)) begin
      @(posedge clk); #1;
      wait_n++;
    end
    repeat (3) begin @(posedge clk); #1; end
    `CHECK("tx_count", tx_log.size(), n_exp)
    if (tx_log.size() > 0) begin
      `CHECK("resp_cycle", tx_log[0].cyc, exp_cyc)
      `CHECK("resp_byte", tx_log[0].val, exp_byte)
    end
    if (ok) begin
      `CHECK("set_count", set_log.size(), 2)
      if (set_log.size() == 2) begin
        `CHECK("addr_set_cycle", set_log[0].cyc, c + 1)
        `CHECK("addr_word", set_log[0].val, addr)
        `CHECK("data_set_cycle", set_log[1].cyc, c + H + 2)
        `CHECK("data_word", set_log[1].val, data)
      end
      for (int k = 2; k <= H + 1; k++) begin
        `CHECK("hold_word", inst_log[c + k], data)
      end
`ifdef CTRL_CMD_ECHO_EN
      for (int k = 1; k < 5; k++) begin
        if (tx_log.size() > k) begin
          `CHECK("echo_byte", tx_log[k].val, {8'h00, echo_b[k-1]})
          `CHECK("echo_cycle", tx_log[k].cyc, exp_cyc + k)
        end
      end
`endif
    end else begin
      `CHECK("set_count", set_log.size(), 0)
      if (exp_err < 255) exp_err++;
    end
    `CHECK("errcnt", bus.o_errcnt, 8'(exp_err))
    `CHECK("idle_after_frame", bus.o_busy, 1'b0)
    clear_logs();
  endtask

  task automatic run_frame(input logic [7:0] ah, al, dh, dl, ck, input int maxgap);
    int c;
    send_frame(ah, al, dh, dl, ck, maxgap, c);
    check_frame(ah, al, dh, dl, ck, c);
  endtask

  initial begin
    int          c, a2, f, t;
    logic        busy_ok;
    logic [7:0]  ah, al, dh, dl, ck;
    bus.i_rxdata  = 8'h00;
    bus.i_rxvalid = 1'b0;
    bus.i_txfull  = 1'b0;

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    `CHECK("rst_inst", bus.o_inst, 16'h0000)
    `CHECK("rst_set", bus.o_set, 1'b0)
    `CHECK("rst_txdata", bus.o_txdata, 8'h00)
    `CHECK("rst_txwrite", bus.o_txwrite, 1'b0)
    `CHECK("rst_busy", bus.o_busy, 1'b0)
    `CHECK("rst_errcnt", bus.o_errcnt, 8'h00)
    @(posedge clk); #1;
    rst = 1'b0;
    clear_logs();

    // Basic accepted command, bad checksum, address out of range, last valid address
    run_frame(8'h00, 8'h0A, 8'h00, 8'h03, 8'h09, 0);
    run_frame(8'h00, 8'h0A, 8'h00, 8'h03, 8'h08, 0);
    run_frame(8'h00, 8'h24, 8'h00, 8'h01, 8'h25, 2);
    run_frame(8'h00, 8'h23, 8'hBE, 8'hEF, 8'h23 ^ 8'hBE ^ 8'hEF, 1);
    run_frame(8'h00, 8'h05, SYNC_B, SYNC_B, 8'h05, 0);

    // Timeout after a partial frame, then a normal frame
    send_byte(SYNC_B, 0, t);
    send_byte(8'h00, 0, t);
    send_byte(8'h01, 0, a2);
    while (cyc < a2 + T) begin @(posedge clk); #1; end
    @(negedge clk);
    `CHECK("tmo_busy_last", bus.o_busy, 1'b1)
    @(posedge clk); #1;
    @(negedge clk);
    `CHECK("tmo_busy_after", bus.o_busy, 1'b0)
    exp_err++;
    `CHECK("tmo_errcnt", bus.o_errcnt, 8'(exp_err))
    @(posedge clk); #1;
    `CHECK("tmo_no_write", tx_log.size(), 0)
    clear_logs();
    run_frame(8'h00, 8'h01, 8'h00, 8'hFF, 8'hFE, 0);

    // Transmitter full during the response; bytes arriving meanwhile are dropped
    bus.i_txfull = 1'b1;
    send_frame(8'h00, 8'h05, 8'h12, 8'h34, 8'h23, 0, c);
    busy_ok = 1'b1;
    for (int k = 0; k < 50; k++) begin
      bus.i_rxvalid = ((k % 7) == 3);
      bus.i_rxdata  = ((k % 14) == 3) ? SYNC_B : 8'($urandom);
      @(negedge clk);
      if (bus.o_busy !== 1'b1) busy_ok = 1'b0;
      @(posedge clk); #1;
    end
    bus.i_rxvalid = 1'b0;
    `CHECK("full_no_write", tx_log.size(), 0)
    `CHECK("full_busy", busy_ok, 1'b1)
    `CHECK("full_set_count", set_log.size(), 2)
    f = cyc;
    bus.i_txfull = 1'b0;
    repeat (8) begin @(posedge clk); #1; end
    `CHECK("full_write_seen", tx_log.size() > 0, 1'b1)
    if (tx_log.size() > 0) begin
      `CHECK("full_write_cycle", tx_log[0].cyc, f)
      `CHECK("full_write_byte", tx_log[0].val, {8'h00, ACK_B})
    end
    clear_logs();
    run_frame(8'h00, 8'h10, 8'hCA, 8'hFE, 8'h10 ^ 8'hCA ^ 8'hFE, 0);

    // Randomized frames, with stray non-SYNC bytes between them
    for (int i = 0; i < 24; i++) begin
      ah = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      al = 8'($urandom);
      dh = 8'($urandom);
      dl = 8'($urandom);
      ck = ah ^ al ^ dh ^ dl;
      if ($urandom_range(0, 3) == 0) ck = ck ^ 8'($urandom_range(1, 255));
      send_byte(8'h3C, int'($urandom_range(0, 2)), t);
      run_frame(ah, al, dh, dl, ck, 3);
    end

    // Saturate the error counter
    for (int i = 0; i < 260; i++) begin
      run_frame(8'h00, 8'h02, 8'h00, 8'h00, 8'h00, 0);
    end
    `CHECK("errcnt_saturated", bus.o_errcnt, 8'hFF)

    // Reset while holding data between the two o_set pulses
    send_frame(8'h00, 8'h07, 8'h55, 8'hAA, 8'h07 ^ 8'h55 ^ 8'hAA, 0, c);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    `CHECK("pre_rst_hold_word", bus.o_inst, 16'h55AA)
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    `CHECK("mid_rst_inst", bus.o_inst, 16'h0000)
    `CHECK("mid_rst_set", bus.o_set, 1'b0)
    `CHECK("mid_rst_txdata", bus.o_txdata, 8'h00)
    `CHECK("mid_rst_txwrite", bus.o_txwrite, 1'b0)
    `CHECK("mid_rst_busy", bus.o_busy, 1'b0)
    `CHECK("mid_rst_errcnt", bus.o_errcnt, 8'h00)
    exp_err = 0;
    repeat (4) begin @(posedge clk); #1; end
    `CHECK("mid_rst_no_write", tx_log.size(), 0)
    clear_logs();
    run_frame(8'h00, 8'h07, 8'h55, 8'hAA, 8'h07 ^ 8'h55 ^ 8'hAA, 0);
    run_frame(8'h00, 8'h07, 8'h55, 8'hAA, 8'h07 ^ 8'h55 ^ 8'hAA, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
